// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM state encoding,
// line levels and the default prescale width.
package uart_pkg;

  localparam int unsigned UART_PRESCALE_WIDTH = 16;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter; bit_tick marks the last cycle of each bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [PRESCALE_WIDTH-1:0] period,
  input  logic                      enable,
  output logic                      bit_tick
);

  logic [PRESCALE_WIDTH-1:0] reload;
  logic [PRESCALE_WIDTH-1:0] count;
  logic [PRESCALE_WIDTH-1:0] load_val;

  // A period of 0 behaves as 1, so both reload to a count of 0.
  assign load_val = (period == '0) ? '0 : period - PRESCALE_WIDTH'(1);
  assign bit_tick = enable && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload <= '0;
      count  <= '0;
    end else if (load) begin
      reload <= load_val;
      count  <= load_val;
    end else if (enable) begin
      count <= (count == '0) ? reload : count - PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI4-Stream to UART serializer: start bit, LSB-first data, optional even
// parity (AXIS_UART_TX_PARITY_EN), stop bit.
module axis_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      txd,
  output logic                      busy
);

  localparam int unsigned BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  uart_state_t               state;
  logic [DATA_WIDTH-1:0]     shift;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic                      handshake;
  logic                      bit_tick;
`ifdef AXIS_UART_TX_PARITY_EN
  logic                      parity;
`endif

  assign s_axis_tready = (state == ST_IDLE) && rst_n;
  assign handshake     = s_axis_tvalid && s_axis_tready;

  uart_baud_gen #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_baud_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (handshake),
    .period   (prescale),
    .enable   (state != ST_IDLE),
    .bit_tick (bit_tick)
  );

  // txd is registered, so each transition loads the level of the next bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      txd     <= UART_IDLE_LEVEL;
      busy    <= 1'b0;
      shift   <= '0;
      bit_cnt <= '0;
`ifdef AXIS_UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            state   <= ST_START;
            txd     <= UART_START_LEVEL;
            busy    <= 1'b1;
            shift   <= s_axis_tdata;
            bit_cnt <= '0;
`ifdef AXIS_UART_TX_PARITY_EN
            parity  <= ^s_axis_tdata;
`endif
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state <= ST_DATA;
            txd   <= shift[0];
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef AXIS_UART_TX_PARITY_EN
              state <= ST_PARITY;
              txd   <= parity;
`else
              state <= ST_STOP;
              txd   <= UART_IDLE_LEVEL;
`endif
            end else begin
              shift   <= shift >> 1;
              txd     <= shift[1];
              bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
            end
          end
        end
`ifdef AXIS_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            state <= ST_STOP;
            txd   <= UART_IDLE_LEVEL;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick) begin
            state <= ST_IDLE;
            txd   <= UART_IDLE_LEVEL;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          txd   <= UART_IDLE_LEVEL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Randomized self-checking bench for axis_uart_tx against a bit-list frame model.
module tb_axis_uart_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 16;
`ifdef AXIS_UART_TX_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [PW-1:0] prescale;
  logic          txd;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axis_uart_tx #(
    .DATA_WIDTH     (DW),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .prescale      (prescale),
    .txd           (txd),
    .busy          (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Offers one word, then checks every cycle of the frame against the list of
  // line levels the UART framing rules give for that word and period.
  task automatic send_frame(input logic [DW-1:0] data, input logic [PW-1:0] presc,
                            input logic [PW-1:0] presc_next, input bit hold_valid,
                            input bit expect_immediate, output logic [DW-1:0] decoded,
                            output logic after_data);
    int unsigned p;
    int unsigned waited;
    logic        frame_bits[$];
    frame_bits = {};
    p = (presc == '0) ? 1 : int'(presc);
    frame_bits.push_back(1'b0);
    for (int unsigned i = 0; i < DW; i++) frame_bits.push_back(data[i]);
    if (PARITY) frame_bits.push_back(^data);
    frame_bits.push_back(1'b1);
    decoded    = '0;
    after_data = 1'b0;

    s_axis_tdata  = data;
    prescale      = presc;
    s_axis_tvalid = 1'b1;
    waited = 0;
    while (!s_axis_tready && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!s_axis_tready) begin
      check_eq("hs_timeout", 0, 1);
      s_axis_tvalid = 1'b0;
      return;
    end
    if (expect_immediate) check_eq("hs_immediate", waited, 0);
    @(posedge clk); #1;
    prescale = presc_next;
    if (!hold_valid) begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = ~data;
    end

    for (int unsigned b = 0; b < frame_bits.size(); b++) begin
      for (int unsigned c = 0; c < p; c++) begin
        check_eq("txd", txd, frame_bits[b]);
        check_eq("busy", busy, 1);
        check_eq("tready", s_axis_tready, 0);
        if (c == p / 2) begin
          if (b >= 1 && b <= DW) decoded[b-1] = txd;
          if (b == DW + 1) after_data = txd;
        end
        @(posedge clk); #1;
      end
    end
    check_eq("end_tready", s_axis_tready, 1);
    check_eq("end_busy", busy, 0);
    check_eq("end_txd", txd, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] dec;
    logic          aft;
    logic [DW-1:0] d;
    logic [PW-1:0] ps;
    bit            hold;
    bit            prev_hold;

    rst_n         = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h5A;
    prescale      = 16'd4;
    #2;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("rst_txd", txd, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_tready", s_axis_tready, 0);
    end
    s_axis_tvalid = 1'b0;
    rst_n         = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_tready", s_axis_tready, 1);
    check_eq("post_rst_busy", busy, 0);

    // Single frame, 0x55 at prescale 4
    send_frame(8'h55, 16'd4, 16'd4, 1'b0, 1'b0, dec, aft);
    check_eq("dec_55", dec, 8'h55);

    // Back-to-back with tvalid held
    send_frame(8'hA3, 16'd2, 16'd2, 1'b1, 1'b0, dec, aft);
    check_eq("dec_A3", dec, 8'hA3);
    send_frame(8'h0F, 16'd2, 16'd2, 1'b0, 1'b1, dec, aft);
    check_eq("dec_0F", dec, 8'h0F);

    // prescale 0 acts as 1
    send_frame(8'hC6, 16'd0, 16'd0, 1'b0, 1'b0, dec, aft);
    check_eq("dec_p0", dec, 8'hC6);

    // prescale change mid-frame takes effect on the next frame
    send_frame(8'h39, 16'd4, 16'd8, 1'b0, 1'b0, dec, aft);
    check_eq("dec_p4", dec, 8'h39);
    send_frame(8'h9E, 16'd8, 16'd8, 1'b0, 1'b0, dec, aft);
    check_eq("dec_p8", dec, 8'h9E);

    // Parity bit (or stop bit directly after data)
    send_frame(8'h07, 16'd3, 16'd3, 1'b0, 1'b0, dec, aft);
    check_eq("after_data_07", aft, PARITY ? 1 : 1);
    send_frame(8'h03, 16'd3, 16'd3, 1'b0, 1'b0, dec, aft);
    check_eq("after_data_03", aft, PARITY ? 0 : 1);

    // Reset during data bit 3 (0x34 has bit 3 low)
    s_axis_tdata  = 8'h34;
    prescale      = 16'd4;
    s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check_eq("pre_rst_txd", txd, 0);
    check_eq("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_txd", txd, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_tready", s_axis_tready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(8'h81, 16'd4, 16'd4, 1'b0, 1'b0, dec, aft);
    check_eq("dec_81", dec, 8'h81);

    // Randomized frames, periods and gaps
    prev_hold = 1'b0;
    for (int i = 0; i < 24; i++) begin
      d    = DW'($urandom);
      ps   = PW'($urandom_range(0, 5));
      hold = (i != 23) && ($urandom_range(0, 1) == 1);
      send_frame(d, ps, PW'($urandom_range(0, 5)), hold, prev_hold, dec, aft);
      check_eq("dec_rand", dec, d);
      check_eq("after_data_rand", aft, PARITY ? ^d : 1'b1);
      if (!hold) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      prev_hold = hold;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
